// File: rtl/serial_adder_n.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_n
//  Function : Digit-serial adder/subtractor. Processes DIGIT bits per clock
//             through a ripple of full-adder cells with a registered carry.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int               c_N      = WIDTH / DIGIT;
    localparam int               c_CNT_W  = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N - 1);
    localparam logic [0:0]       c_S_IDLE = 1'b0;
    localparam logic [0:0]       c_S_RUN  = 1'b1;

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_adder_n: DIGIT must be >= 1 and divide WIDTH exactly");
    end

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_psum;
    logic               r_a_msb;
    logic               r_b_msb;
    logic [WIDTH-1:0]   r_sum;
    logic               r_c_out;
    logic               r_ovf;
    logic               r_done;
    logic [WIDTH-1:0]   w_b_in;
    logic [DIGIT-1:0]   w_dsum;
    logic               w_dcarry;
    logic [WIDTH-1:0]   w_psum_next;
    logic               w_ovf_final;

    assign w_b_in = sub ? ~b : b;

    // One digit of full-adder cells rippling from the registered carry.
    always_comb begin
        logic w_c;
        w_c    = r_carry;
        w_dsum = '0;
        for (int i = 0; i < DIGIT; i++) begin
            w_dsum[i] = r_a[i] ^ r_b[i] ^ w_c;
            w_c       = (r_a[i] & r_b[i]) | (w_c & (r_a[i] ^ r_b[i]));
        end
        w_dcarry = w_c;
    end

    // New digit enters at the top so the LSB digit ends up at bit 0 after N steps.
    assign w_psum_next = (r_psum >> DIGIT) | (WIDTH'(w_dsum) << (WIDTH - DIGIT));
    assign w_ovf_final = (r_a_msb == r_b_msb) && (w_psum_next[WIDTH-1] != r_a_msb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_S_RUN;
                end
            end
            c_S_RUN: begin
                if (r_cnt == c_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_psum  <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= w_b_in;
                r_carry <= sub ? 1'b1 : c_in;
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= w_b_in[WIDTH-1];
                r_cnt   <= '0;
            end else if (r_state == c_S_RUN) begin
                r_a     <= r_a >> DIGIT;
                r_b     <= r_b >> DIGIT;
                r_carry <= w_dcarry;
                r_psum  <= w_psum_next;
                r_cnt   <= r_cnt + 1'b1;
                if (w_last) begin
                    r_sum   <= w_psum_next;
                    r_c_out <= w_dcarry;
                    r_ovf   <= w_ovf_final;
                end
            end
        end
    end

    assign busy  = (r_state == c_S_RUN);
    assign done  = r_done;
    assign sum   = r_sum;
    assign c_out = r_c_out;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder_n
//  Function : Scoreboard bench for serial_adder_n (8/2, 4/1 and 4/4 configs).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder_n;

    typedef struct packed {
        logic [7:0] sum;
        logic       c_out;
        logic       ovf;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       s8_start = 1'b0, s8_sub = 1'b0, s8_cin = 1'b0;
    logic [7:0] s8_a = '0, s8_b = '0;
    logic       s8_busy, s8_done, s8_cout, s8_ovf;
    logic [7:0] s8_sum;

    logic       x_start = 1'b0, x_sub = 1'b0, x_cin = 1'b0;
    logic [3:0] x_a = '0, x_b = '0;
    logic       x1_busy, x1_done, x1_cout, x1_ovf;
    logic       x4_busy, x4_done, x4_cout, x4_ovf;
    logic [3:0] x1_sum, x4_sum;

    exp_t q8[$];
    exp_t q1[$];
    exp_t q4[$];

    serial_adder_n #(.WIDTH(8), .DIGIT(2)) u_d8 (
        .clk(clk), .rst(rst), .start(s8_start), .sub(s8_sub), .a(s8_a), .b(s8_b),
        .c_in(s8_cin), .busy(s8_busy), .done(s8_done), .sum(s8_sum),
        .c_out(s8_cout), .ovf(s8_ovf));

    serial_adder_n #(.WIDTH(4), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(x_start), .sub(x_sub), .a(x_a), .b(x_b),
        .c_in(x_cin), .busy(x1_busy), .done(x1_done), .sum(x1_sum),
        .c_out(x1_cout), .ovf(x1_ovf));

    serial_adder_n #(.WIDTH(4), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(x_start), .sub(x_sub), .a(x_a), .b(x_b),
        .c_in(x_cin), .busy(x4_busy), .done(x4_done), .sum(x4_sum),
        .c_out(x4_cout), .ovf(x4_ovf));

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Arithmetic reference: integer add/sub plus signed range test.
    function automatic exp_t model(input int w, input int av, input int bv,
                                   input logic sb, input logic ci);
        exp_t e;
        int   sa, sbv, tot, stot;
        sa  = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
        sbv = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
        if (!sb) begin
            tot     = av + bv + int'(ci);
            e.c_out = (tot >= (1 << w));
            stot    = sa + sbv + int'(ci);
        end else begin
            tot     = av - bv;
            e.c_out = (av >= bv);
            stot    = sa - sbv;
        end
        e.sum = 8'(tot & ((1 << w) - 1));
        e.ovf = (stot > (1 << (w - 1)) - 1) || (stot < -(1 << (w - 1)));
        e.acc = 0;
        return e;
    endfunction

    // Monitor for the 8-bit instance: result, latency, busy length, hold stability.
    int         busy8 = 0;
    logic [7:0] held_sum = '0;
    logic       held_c = 1'b0, held_o = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy8 = 0; held_sum = '0; held_c = 1'b0; held_o = 1'b0;
        end else begin
            if (s8_busy) busy8++;
            if (s8_done) begin
                if (q8.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL d8 unexpected done: sum %0h, nothing expected", s8_sum);
                end else begin
                    e = q8.pop_front();
                    chk("d8 sum", int'(s8_sum), int'(e.sum));
                    chk("d8 c_out", int'(s8_cout), int'(e.c_out));
                    chk("d8 ovf", int'(s8_ovf), int'(e.ovf));
                    chk("d8 latency", cyc - e.acc, 4);
                    chk("d8 busy cycles", busy8, 4);
                    held_sum = e.sum; held_c = e.c_out; held_o = e.ovf;
                end
                busy8 = 0;
            end else if (s8_busy) begin
                chk("d8 held result", int'({s8_sum, s8_cout, s8_ovf}),
                    int'({held_sum, held_c, held_o}));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && x1_done) begin
            if (q1.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL d1 unexpected done: sum %0h, nothing expected", x1_sum);
            end else begin
                e = q1.pop_front();
                chk("d1 result", int'({x1_sum, x1_cout, x1_ovf}), int'({e.sum[3:0], e.c_out, e.ovf}));
                chk("d1 latency", cyc - e.acc, 4);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && x4_done) begin
            if (q4.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL d4 unexpected done: sum %0h, nothing expected", x4_sum);
            end else begin
                e = q4.pop_front();
                chk("d4 result", int'({x4_sum, x4_cout, x4_ovf}), int'({e.sum[3:0], e.c_out, e.ovf}));
                chk("d4 latency", cyc - e.acc, 1);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue8(input logic sb, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic [7:0] es, input logic eco, input logic eov);
        exp_t e;
        int   t;
        t = 0;
        while (s8_busy && t < 50) begin @(negedge clk); t++; end
        if (s8_busy) begin
            n_cmp++; n_err++;
            $display("FAIL d8 idle wait: busy %0b, required 0", s8_busy);
        end
        s8_sub = sb; s8_a = av; s8_b = bv; s8_cin = ci; s8_start = 1'b1;
        e.sum = es; e.c_out = eco; e.ovf = eov; e.acc = cyc + 1;
        q8.push_back(e);
        @(negedge clk);
        s8_start = 1'b0; s8_a = ~av; s8_b = ~bv; s8_sub = ~sb; s8_cin = ~ci;
    endtask

    task automatic issue4(input logic sb, input logic [3:0] av, input logic [3:0] bv, input logic ci);
        exp_t e;
        int   t;
        t = 0;
        while ((x1_busy || x4_busy) && t < 50) begin @(negedge clk); t++; end
        if (x1_busy || x4_busy) begin
            n_cmp++; n_err++;
            $display("FAIL x idle wait: busy %0b/%0b, required 0", x1_busy, x4_busy);
        end
        x_sub = sb; x_a = av; x_b = bv; x_cin = ci; x_start = 1'b1;
        e = model(4, int'(av), int'(bv), sb, ci);
        e.acc = cyc + 1;
        q1.push_back(e);
        q4.push_back(e);
        @(negedge clk);
        x_start = 1'b0; x_a = ~av; x_b = ~bv;
    endtask

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        #1 rst = 1'b1;
        #2;
        chk("reset outputs", int'({s8_busy, s8_done, s8_sum, s8_cout, s8_ovf}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue8(1'b0, 8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b1);
        @(negedge clk);
        // Second start two cycles into the run must be ignored.
        s8_start = 1'b1; s8_a = 8'h11; s8_b = 8'h22; s8_sub = 1'b1; s8_cin = 1'b0;
        @(negedge clk);
        s8_start = 1'b0;
        issue8(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        issue8(1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        issue8(1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        issue8(1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
        issue8(1'b1, 8'h55, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0);
        issue8(1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        issue8(1'b0, 8'hA5, 8'h0F, 1'b1, 8'hB5, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a run discards it.
        issue8(1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid-run reset outputs", int'({s8_busy, s8_done, s8_sum, s8_cout, s8_ovf}), 0);
        q8.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        issue8(1'b0, 8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 1'b0);
        issue8(1'b1, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b0, 1'b0);

        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 2; c++)
                for (int av = 0; av < 16; av++)
                    for (int bv = 0; bv < 16; bv++)
                        issue4(1'(s), 4'(av), 4'(bv), 1'(c));

        t = 0;
        while ((q8.size() != 0 || q1.size() != 0 || q4.size() != 0) && t < 50) begin
            @(negedge clk); t++;
        end
        if (q8.size() != 0 || q1.size() != 0 || q4.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain: pending %0d/%0d/%0d, required 0", q8.size(), q1.size(), q4.size());
        end
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
- Parametrised, multi-cycle successor to the one-bit full adder cell: adds or subtracts two WIDTH-bit operands DIGIT bits per clock.
- Uses a DIGIT-wide ripple of full-adder cells and a registered carry between cycles.
- Start/busy/done handshake; sits beside datapath blocks that trade latency for area.
- Adds a subtract mode and a signed-overflow flag, which the single-bit cell lacks.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 1.
- DIGIT, 2, bits processed per clock; must be >= 1 and divide WIDTH exactly. Violation is an elaboration-time error.
- N (localparam), WIDTH/DIGIT, number of compute cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- sub  input  1  0: a+b+c_in; 1: a-b (c_in ignored); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- c_in  input  1  carry-in for add mode; sampled with start
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- sum  output  WIDTH  result; held until the next completion
- c_out  output  1  carry-out (add), or no-borrow flag (sub: 1 means a>=b unsigned)
- ovf  output  1  two's-complement overflow of the result

Behaviour:
- Reset (asynchronous, any time, including mid-operation): state=IDLE; busy=0, done=0, sum=0, c_out=0, ovf=0; operand shift registers, carry register and digit counter cleared. The in-flight operation is discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, digit counter 0..N-1.
- IDLE, start=1 at edge k:
  - Capture A=a and B'=(sub ? ~b : b).
  - Carry register = sub ? 1 : c_in.
  - Store a[WIDTH-1] and B'[WIDTH-1] for the overflow check.
  - Counter=0, busy=1, go to RUN.
- start=0 in IDLE: no change.
- RUN, each edge k+1..k+N:
  - Low DIGIT bits of A and B' plus the carry register go through the DIGIT-bit ripple.
  - Result digit shifts into the partial-sum register from the top (LSB digit first).
  - A and B' shift right by DIGIT; carry register takes that digit's carry-out; counter increments.
- Final digit (counter=N-1) at edge k+N:
  - sum <= full partial result; c_out <= final carry.
  - ovf <= (A_msb == B'_msb) && (sum_msb != A_msb).
  - done=1 for exactly this one cycle; busy=0; state=IDLE.
- Latency: exactly N clock edges from the accepting edge to the done edge. Throughput: one operation per N+1 cycles at best.
- start while busy=1 is ignored, with no effect on the in-flight operation or its inputs.
- start in the same cycle done=1 is accepted, since busy is already 0. done deasserts at the next edge and the new operation proceeds normally.
- sum, c_out and ovf change only at a done edge or at reset, and are stable throughout RUN.
- a, b, sub and c_in may change freely after the accepting edge.
- Result arithmetic is modulo 2^WIDTH; c_out carries the extra bit.
- DIGIT=WIDTH (N=1): done asserts one edge after acceptance.
- Wrap-around: 0xFF+0x01 (WIDTH=8) gives sum=0x00, c_out=1.

Test Plan:
- WIDTH=8, DIGIT=2: a=0x5A, b=0x3C, c_in=1, sub=0 -> after 4 edges done=1, sum=0x97, c_out=0, ovf=1; busy=1 for exactly 4 cycles.
- a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, ovf=0. a=0x7F, b=0x01 -> sum=0x80, c_out=0, ovf=1.
- sub=1, a=0x10, b=0x20, c_in=1 (ignored) -> sum=0xF0, c_out=0, ovf=0. sub=1, a=0x80, b=0x01 -> sum=0x7F, c_out=1, ovf=1.
- Pulse start again 2 cycles into an operation with different operands -> ignored, first result unchanged. Assert start on the done cycle -> second result appears exactly 4 edges later.
- Assert rst asynchronously mid-RUN (between edges) -> busy, done, sum, c_out and ovf go to 0 immediately. After release, a fresh start completes correctly.
- WIDTH=4 with DIGIT=1 (N=4) and DIGIT=4 (N=1): exhaustive a, b, c_in, sub sweep. Compare against a reference model for sum, c_out and ovf, and check latency equals N.
